uart_record_replay: RTL and testbench



---
 rtl/uart_record_replay.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_record_replay.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_record_replay.sv
// UART recorder/player: valid received payloads are stored in a buffer RAM and
// replayed back-to-back on uart_tx when the (active-low) replay button is pressed.
module uart_record_replay #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int ADDR_W       = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  input  logic              btn_replay_n,
  input  logic              clear,
  output logic [ADDR_W:0]   rx_count,
  output logic              busy,
  output logic              overflow,
  output logic              framing_err,
  output logic              parity_err,
  output logic [2:0]        o_dbg_rx_state,
  output logic [2:0]        o_dbg_tx_state
);

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] C_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_STOP = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] B_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [ADDR_W:0]  DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    par_of = (PARITY == 2) ? ~(^d) : ^d;
  endfunction

  logic r_rx_s1, r_rx_s2, r_btn_s1, r_btn_s2, r_btn_s3;

  state_t                r_rx_state;
  logic [CNT_W-1:0]      r_rx_cnt;
  logic [BIT_W-1:0]      r_rx_bits;
  logic [DATA_BITS-1:0]  r_rx_shift;
  logic                  r_rx_perr;
  logic [ADDR_W:0]       r_rx_count;
  logic                  r_overflow, r_framing_err, r_parity_err;
  logic [DATA_BITS-1:0]  r_mem [2**ADDR_W];

  state_t                r_tx_state;
  logic                  r_tx, r_busy, r_tx_par, r_stop_req;
  logic [CNT_W-1:0]      r_tx_cnt;
  logic [BIT_W-1:0]      r_tx_bits;
  logic [DATA_BITS-1:0]  r_tx_shift;
  logic [ADDR_W-1:0]     r_tx_addr;
  logic [ADDR_W:0]       r_tx_idx, r_tx_len;

  logic w_stop_smp, w_par_bad, w_rx_valid, w_store, w_btn_fall, w_trigger;
  logic [DATA_BITS-1:0] w_rd_first, w_rd_next;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_btn_s3 <= 1'b1;
    end else begin
      r_rx_s1  <= uart_rx;
      r_rx_s2  <= r_rx_s1;
      r_btn_s1 <= btn_replay_n;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
    end
  end

  assign w_stop_smp = (r_rx_state == S_STOP) && (r_rx_cnt == C_BIT);
  assign w_par_bad  = (r_rx_state == S_PAR) && (r_rx_cnt == C_BIT) &&
                      (r_rx_s2 != par_of(r_rx_shift));
  assign w_rx_valid = w_stop_smp && r_rx_s2 && !r_rx_perr;
  // clear takes priority over a byte completing in the same cycle
  assign w_store    = w_rx_valid && !clear && (r_rx_count != DEPTH);
  assign w_btn_fall = r_btn_s3 && !r_btn_s2;
  assign w_trigger  = w_btn_fall && (r_tx_state == S_IDLE) && (r_rx_count != '0) && !clear;
  assign w_rd_first = r_mem[0];
  assign w_rd_next  = r_mem[r_tx_addr + 1'b1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt  <= '0;
          r_rx_bits <= '0;
          r_rx_perr <= 1'b0;
          if (!r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_rx_cnt == C_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (r_rx_cnt == C_BIT) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bits == B_LAST) begin
              r_rx_bits  <= '0;
              r_rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else r_rx_bits <= r_rx_bits + 1'b1;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_PAR: begin
          if (r_rx_cnt == C_BIT) begin
            r_rx_cnt   <= '0;
            r_rx_perr  <= w_par_bad;
            r_rx_state <= S_STOP;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_STOP: begin
          if (r_rx_cnt == C_BIT) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_BREAK;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_BREAK: if (r_rx_s2) r_rx_state <= S_IDLE;
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_count    <= '0;
      r_overflow    <= 1'b0;
      r_framing_err <= 1'b0;
      r_parity_err  <= 1'b0;
    end else if (clear) begin
      r_rx_count    <= '0;
      r_overflow    <= 1'b0;
      r_framing_err <= 1'b0;
      r_parity_err  <= 1'b0;
    end else begin
      if (w_rx_valid) begin
        if (r_rx_count == DEPTH) r_overflow <= 1'b1;
        else r_rx_count <= r_rx_count + 1'b1;
      end
      if (w_stop_smp && !r_rx_s2) r_framing_err <= 1'b1;
      if (w_par_bad) r_parity_err <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_store) r_mem[r_rx_count[ADDR_W-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_tx_state <= S_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_par   <= 1'b0;
      r_stop_req <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '0;
      r_tx_addr  <= '0;
      r_tx_idx   <= '0;
      r_tx_len   <= '0;
    end else begin
      if (clear && (r_tx_state != S_IDLE)) r_stop_req <= 1'b1;
      case (r_tx_state)
        S_IDLE: begin
          r_stop_req <= 1'b0;
          if (w_trigger) begin
            r_tx_len   <= r_rx_count;
            r_tx_idx   <= '0;
            r_tx_addr  <= '0;
            r_tx_shift <= w_rd_first;
            r_tx_par   <= par_of(w_rd_first);
            r_tx_cnt   <= '0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == C_BIT) begin
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_state <= S_DATA;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_DATA: begin
          if (r_tx_cnt == C_BIT) begin
            r_tx_cnt <= '0;
            if (r_tx_bits == B_LAST) begin
              r_tx       <= (PARITY != 0) ? r_tx_par : 1'b1;
              r_tx_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_tx_bits  <= r_tx_bits + 1'b1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_PAR: begin
          if (r_tx_cnt == C_BIT) begin
            r_tx_cnt   <= '0;
            r_tx       <= 1'b1;
            r_tx_state <= S_STOP;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_STOP: begin
          if (r_tx_cnt == C_STOP) begin
            r_tx_cnt <= '0;
            // a pending clear lets the current frame finish, then ends the replay
            if (r_stop_req || clear || ((r_tx_idx + 1'b1) == r_tx_len)) begin
              r_busy     <= 1'b0;
              r_tx_state <= S_IDLE;
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx_addr  <= r_tx_addr + 1'b1;
              r_tx_shift <= w_rd_next;
              r_tx_par   <= par_of(w_rd_next);
              r_tx       <= 1'b0;
              r_tx_state <= S_START;
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx        = r_tx;
  assign busy           = r_busy;
  assign rx_count       = r_rx_count;
  assign overflow       = r_overflow;
  assign framing_err    = r_framing_err;
  assign parity_err     = r_parity_err;
  assign o_dbg_rx_state = r_rx_state;
  assign o_dbg_tx_state = r_tx_state;

endmodule

// File: tb/tb_uart_record_replay.sv
// Directed bench for uart_record_replay: three instances (8N1, 8E1, 7N2), 16-cycle bits,
// 4-entry buffer.
module tb_uart_record_replay;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic rx[3];
  logic btn_n[3];
  logic tx[3], busy[3], ovf[3], ferr[3], perr[3];
  logic [2:0] cnt[3], dbg_rx[3], dbg_tx[3];
  int checks = 0;
  int errors = 0;
  int n;
  logic [63:0] obs;
  logic [15:0] w, bs;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_record_replay #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   ((g == 2) ? 7 : 8),
      .PARITY      ((g == 1) ? 1 : 0),
      .STOP_BITS   ((g == 2) ? 2 : 1),
      .ADDR_W      (2)
    ) dut (
      .sys_clk       (clk),
      .sys_rst       (rst),
      .uart_rx       (rx[g]),
      .uart_tx       (tx[g]),
      .btn_replay_n  (btn_n[g]),
      .clear         (clear),
      .rx_count      (cnt[g]),
      .busy          (busy[g]),
      .overflow      (ovf[g]),
      .framing_err   (ferr[g]),
      .parity_err    (perr[g]),
      .o_dbg_rx_state(dbg_rx[g]),
      .o_dbg_tx_state(dbg_tx[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic uart_send(input int k, input logic [7:0] d, input int nb,
                           input bit use_par, input logic pbit, input int nstop);
    rx[k] = 1'b0;
    tick(CPB);
    for (int i = 0; i < nb; i++) begin
      rx[k] = d[i];
      tick(CPB);
    end
    if (use_par) begin
      rx[k] = pbit;
      tick(CPB);
    end
    rx[k] = 1'b1;
    tick(CPB * nstop);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  // Counts cycles while busy is high, sampling uart_tx mid-bit into bit slots.
  task automatic run_busy(input int k, output int len, output logic [63:0] o);
    len = 0;
    o = '0;
    while (busy[k] === 1'b1 && len < 1000) begin
      if (len % CPB == CPB / 2) o[len / CPB] = tx[k];
      len++;
      tick(1);
    end
  endtask

  task automatic capture(input int k, input int nb, output logic [15:0] wv, output logic [15:0] bv);
    int t;
    t = 0;
    wv = '0;
    bv = '0;
    while (tx[k] === 1'b1 && t < 400) begin
      t++;
      tick(1);
    end
    check($sformatf("cap%0d_start", k), tx[k], 0);
    tick(CPB / 2);
    for (int b = 0; b < nb; b++) begin
      wv[b] = tx[k];
      bv[b] = busy[k];
      tick(CPB);
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx[k] = 1'b1;
      btn_n[k] = 1'b1;
    end
    tick(3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_tx%0d", k), tx[k], 1);
      check($sformatf("rst_busy%0d", k), busy[k], 0);
      check($sformatf("rst_cnt%0d", k), cnt[k], 0);
      check($sformatf("rst_flags%0d", k), {ovf[k], ferr[k], perr[k]}, 0);
      check($sformatf("rst_fsm%0d", k), {dbg_rx[k], dbg_tx[k]}, 0);
    end
    rst = 1'b0;
    tick(3);

    // 8N1 record two bytes and replay them back-to-back
    uart_send(0, 8'h41, 8, 0, 1'b0, 1);
    uart_send(0, 8'h42, 8, 0, 1'b0, 1);
    check("t1_count", cnt[0], 2);
    btn_n[0] = 1'b0;
    tick(2);
    check("t1_lat2", tx[0], 1);
    tick(1);
    check("t1_lat3", tx[0], 0);
    run_busy(0, n, obs);
    check("t1_busy_len", n, 320);
    check("t1_stream", obs[19:0], {1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0});
    check("t1_idle", tx[0], 1);
    btn_n[0] = 1'b1;
    tick(10);
    btn_n[0] = 1'b0;
    tick(3);
    run_busy(0, n, obs);
    check("t1_rebusy_len", n, 320);
    check("t1_restream", obs[19:0], {1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0});
    btn_n[0] = 1'b1;
    tick(10);

    // even parity: 0x07 needs parity 1, send 0 -> rejected; 0x03 with parity 0 -> stored
    uart_send(1, 8'h07, 8, 1, 1'b0, 1);
    check("t2_perr", perr[1], 1);
    check("t2_cnt0", cnt[1], 0);
    uart_send(1, 8'h03, 8, 1, 1'b0, 1);
    check("t2_cnt1", cnt[1], 1);
    btn_n[1] = 1'b0;
    capture(1, 11, w, bs);
    check("t2_frame", w[10:0], {1'b1, 1'b0, 8'h03, 1'b0});
    btn_n[1] = 1'b1;
    tick(20);

    // 7 data bits, 2 stop bits
    uart_send(2, 8'h55, 7, 0, 1'b0, 2);
    check("t3_cnt", cnt[2], 1);
    btn_n[2] = 1'b0;
    capture(2, 10, w, bs);
    check("t3_frame", w[9:0], {2'b11, 7'h55, 1'b0});
    check("t3_busy_stop2", bs[9], 1);
    btn_n[2] = 1'b1;
    tick(20);

    // overflow on a 4-entry buffer, then clear
    pulse_clear();
    check("t4_clr_cnt", cnt[0], 0);
    uart_send(0, 8'h11, 8, 0, 1'b0, 1);
    uart_send(0, 8'h22, 8, 0, 1'b0, 1);
    uart_send(0, 8'h33, 8, 0, 1'b0, 1);
    uart_send(0, 8'h44, 8, 0, 1'b0, 1);
    check("t4_cnt4", cnt[0], 4);
    check("t4_ovf0", ovf[0], 0);
    uart_send(0, 8'h55, 8, 0, 1'b0, 1);
    check("t4_cnt_full", cnt[0], 4);
    check("t4_ovf1", ovf[0], 1);

    // clear mid-replay: the first frame completes, then the replay stops
    btn_n[0] = 1'b0;
    tick(3);
    check("t5_start", busy[0], 1);
    tick(20);
    pulse_clear();
    check("t5_cnt", cnt[0], 0);
    check("t5_ovf", ovf[0], 0);
    run_busy(0, n, obs);
    check("t5_busy_rest", n, 139);
    btn_n[0] = 1'b1;
    tick(10);

    // short glitch is ignored
    rx[0] = 1'b0;
    tick(8);
    rx[0] = 1'b1;
    tick(40);
    check("t6_glitch_cnt", cnt[0], 0);
    check("t6_glitch_flags", {ferr[0], perr[0]}, 0);

    // break condition: framing error, then reception resumes
    rx[0] = 1'b0;
    tick(12 * CPB);
    check("t6_break_ferr", ferr[0], 1);
    check("t6_break_cnt", cnt[0], 0);
    rx[0] = 1'b1;
    tick(2 * CPB);
    uart_send(0, 8'h5A, 8, 0, 1'b0, 1);
    check("t6_resume_cnt", cnt[0], 1);
    check("t6_ferr_sticky", ferr[0], 1);

    // reset mid-replay: line returns high without waiting for a clock edge
    btn_n[0] = 1'b0;
    tick(33);
    check("t7_mid_low", tx[0], 0);
    rst = 1'b1;
    #1;
    check("t7_tx", tx[0], 1);
    check("t7_busy", busy[0], 0);
    check("t7_cnt", cnt[0], 0);
    check("t7_ferr", ferr[0], 0);
    tick(3);
    rst = 1'b0;
    btn_n[0] = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
